event_scheduler: RTL

Front-end scheduler for the RTLola monitor pipeline. It timestamps incoming input events and internally generated periodic deadlines, and buffers them in a small FIFO. It drains the FIFO one event at a time, sequencing the monitor's evaluation layers with one-cycle enable pulses. It sits between the stimulus/input interface and `topEntity`'s stream evaluators, and it owns the `q_push`/`q_pop` status and the `enable_*` signals.

---
 rtl/event_scheduler_pkg.sv | 23 ++
 rtl/event_scheduler_if.sv | 35 +++
 rtl/event_scheduler_fifo.sv | 67 ++++++
 rtl/event_scheduler.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/event_scheduler_pkg.sv
// Shared types and parameter defaults for the RTLola event scheduler front-end.
package scheduler_pkg;

  localparam int unsigned DATA_W_DEF     = 64;
  localparam int unsigned TS_W_DEF       = 64;
  localparam int unsigned DEPTH_DEF      = 4;
  localparam int unsigned NUM_LAYERS_DEF = 3;
  localparam int unsigned PERIOD_DEF     = 1000;

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } sched_state_t;

  // Fields are sized at the default widths; narrower DATA_W/TS_W are extended on store.
  typedef struct packed {
    logic [TS_W_DEF-1:0]          ts;
    logic signed [DATA_W_DEF-1:0] data;
    logic                         is_input;
    logic                         is_periodic;
  } event_t;

endpackage

// File: rtl/event_scheduler_if.sv
// Stimulus-side and evaluator-side signals of the event scheduler.
interface event_scheduler_if
  import scheduler_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned TS_W       = TS_W_DEF,
  parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF
);

  logic signed [DATA_W-1:0] input_0;
  logic                     new_input_0;
  logic signed [DATA_W-1:0] ev_data;
  logic [TS_W-1:0]          ev_ts;
  logic                     q_push;
  logic                     q_push_valid;
  logic                     q_pop;
  logic                     q_pop_valid;
  logic                     enable_in0;
  logic                     enable_periodic;
  logic [NUM_LAYERS-1:0]    enable_layer;
  logic                     overflow;

  modport master (
    output input_0, new_input_0,
    input  ev_data, ev_ts, q_push, q_push_valid, q_pop, q_pop_valid,
    input  enable_in0, enable_periodic, enable_layer, overflow
  );

  modport slave (
    input  input_0, new_input_0,
    output ev_data, ev_ts, q_push, q_push_valid, q_pop, q_pop_valid,
    output enable_in0, enable_periodic, enable_layer, overflow
  );

endinterface

// File: rtl/event_scheduler_fifo.sv
// Synchronous FIFO of scheduler events with registered occupancy, full and empty.
module event_fifo
  import scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  event_t wdata,
  input  logic   pop,
  output event_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  event_t        mem_q [DEPTH];
  event_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push & ~full_q;
    do_pop   = pop & ~empty_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
    end
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d   = (count_d == (AW+1)'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset; only entries below the count are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/event_scheduler.sv
// Timestamps input and periodic events, queues them, and sequences the
// monitor's evaluation layers one event at a time.
module event_scheduler
  import scheduler_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned TS_W       = TS_W_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int unsigned PERIOD     = PERIOD_DEF
) (
  input logic               clk,
  input logic               rst,
  input logic               en,
  event_scheduler_if.slave  bus
);

  localparam int unsigned KW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned CW = $clog2(PERIOD);

  logic [TS_W-1:0] ts_q, ts_d;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            overflow_q, overflow_d;
  sched_state_t    state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  event_t          ev_q, ev_d;

  logic   active;
  logic   tick;
  logic   push, push_valid, pop, pop_valid;
  event_t push_ev, fifo_rdata;
  logic   fifo_full, fifo_empty;

  logic [NUM_LAYERS-1:0] enable_layer;
  logic                  enable_in0, enable_periodic;

  // Event generation; every strobe-type output is forced low in reset and when disabled.
  always_comb begin
    active          = en & ~rst;
    tick            = ~rst & (tick_cnt_q == CW'(PERIOD - 1));
    push            = active & (bus.new_input_0 | tick);
    push_valid      = push & ~fifo_full;
    pop             = active & (state_q == IDLE);
    pop_valid       = pop & ~fifo_empty;
    push_ev.ts          = TS_W_DEF'(ts_q);
    push_ev.data        = bus.new_input_0 ? DATA_W_DEF'(bus.input_0) : '0;
    push_ev.is_input    = bus.new_input_0;
    push_ev.is_periodic = tick;
  end

  always_comb begin
    ts_d       = ts_q;
    tick_cnt_d = tick_cnt_q;
    overflow_d = overflow_q;
    if (en) begin
      ts_d       = ts_q + 1'b1;
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      if (push & fifo_full) begin
        overflow_d = 1'b1;
      end
    end
  end

  event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_valid),
    .wdata (push_ev),
    .pop   (pop_valid),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      ev_q       <= '0;
      ts_q       <= '0;
      tick_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      ev_q       <= ev_d;
      ts_q       <= ts_d;
      tick_cnt_q <= tick_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ev_d    = ev_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (pop_valid) begin
            ev_d    = fifo_rdata;
            k_d     = '0;
            state_d = EVAL;
          end
        end
        EVAL: begin
          if (k_q == KW'(NUM_LAYERS - 1)) begin
            state_d = IDLE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    enable_layer    = '0;
    enable_in0      = 1'b0;
    enable_periodic = 1'b0;
    if (active && state_q == EVAL) begin
      enable_layer = NUM_LAYERS'(1) << k_q;
      if (k_q == '0) begin
        enable_in0      = ev_q.is_input;
        enable_periodic = ev_q.is_periodic;
      end
    end
  end

  assign bus.ev_data         = ev_q.data[DATA_W-1:0];
  assign bus.ev_ts           = ev_q.ts[TS_W-1:0];
  assign bus.q_push          = push;
  assign bus.q_push_valid    = push_valid;
  assign bus.q_pop           = pop;
  assign bus.q_pop_valid     = pop_valid;
  assign bus.enable_in0      = enable_in0;
  assign bus.enable_periodic = enable_periodic;
  assign bus.enable_layer    = enable_layer;
  assign bus.overflow        = overflow_q;

endmodule
